pipe_perf_monitor: RTL and testbench

Synthesizable performance and writeback-trace monitor that attaches to the pipelined CPU's WB stage and hazard unit. It counts cycles, retired register writes, stall cycles and N_EVT generic events in saturating counters readable through a registered select port. It also captures filtered writeback records (rd, data, cycle stamp) into a TRACE_DEPTH FIFO drained over a valid/ready handshake. It replaces ad-hoc simulation-only cycle counters and writeback monitors with hardware usable in both simulation and silicon.

---
 rtl/pipe_perf_monitor.sv | 105 ++++++++++
 tb/tb_pipe_perf_monitor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: saturating perf counters with registered readout plus a filtered writeback trace FIFO
module pipe_perf_monitor #(
    parameter int XLEN        = 64,
    parameter int CNT_W       = 32,
    parameter int N_EVT       = 4,
    parameter int TRACE_DEPTH = 8,
    parameter int SEL_W       = $clog2(N_EVT + 4)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic             wb_reg_write_i,
    input  logic [4:0]       wb_rd_i,
    input  logic [XLEN-1:0]  wb_data_i,
    input  logic             hazard_stall_i,
    input  logic [N_EVT-1:0] evt_i,
    input  logic             filter_en_i,
    input  logic [4:0]       filter_rd_i,
    input  logic [SEL_W-1:0] rd_sel_i,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             sat_o,
    output logic             trc_valid_o,
    input  logic             trc_ready_i,
    output logic [4:0]       trc_rd_o,
    output logic [XLEN-1:0]  trc_data_o,
    output logic [CNT_W-1:0] trc_cycle_o
);
    localparam int NC = N_EVT + 4;
    localparam int AW = $clog2(TRACE_DEPTH);

    logic [CNT_W-1:0] cnt_q [NC];
    logic [CNT_W-1:0] cnt_d [NC];
    logic [CNT_W-1:0] rd_mux [2**SEL_W];
    logic [CNT_W-1:0] rd_data_q;
    logic [NC-1:0]    inc;
    logic             sat_q, sat_d;
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      occ_q;
    logic [4:0]       mem_rd [TRACE_DEPTH];
    logic [XLEN-1:0]  mem_data [TRACE_DEPTH];
    logic [CNT_W-1:0] mem_cyc [TRACE_DEPTH];
    logic             zap, retire, capture, full, pop, push, drop;

    assign zap     = rst | clear_i;
    assign retire  = wb_reg_write_i & (wb_rd_i != 5'd0);
    assign capture = enable_i & retire & (~filter_en_i | (wb_rd_i == filter_rd_i));
    assign full    = occ_q == (AW+1)'(TRACE_DEPTH);
    assign pop     = trc_valid_o & trc_ready_i;
    assign push    = capture & (~full | pop);
    assign drop    = capture & full & ~pop;
    assign inc     = {evt_i & {N_EVT{enable_i}}, drop, enable_i & hazard_stall_i, enable_i & retire, enable_i};

    for (genvar j = 0; j < 2**SEL_W; j++) begin : g_mux
        if (j < NC) begin : g_cnt
            assign rd_mux[j] = cnt_q[j];
        end else begin : g_zero
            assign rd_mux[j] = '0;
        end
    end

    // saturating increment of every counter; sat latches once any counter hits all-ones
    always_comb begin
        sat_d = sat_q;
        for (int k = 0; k < NC; k++) begin
            cnt_d[k] = (inc[k] && !(&cnt_q[k])) ? cnt_q[k] + CNT_W'(1) : cnt_q[k];
            sat_d    = sat_d | (&cnt_d[k]);
        end
    end

    // counter, readout and FIFO pointer state; clear behaves exactly like reset
    always_ff @(posedge clk) begin
        if (zap) begin
            cnt_q     <= '{default: '0};
            sat_q     <= 1'b0;
            rd_data_q <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            occ_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            rd_data_q <= rd_mux[rd_sel_i];
            wp_q      <= wp_q + AW'(push);
            rp_q      <= rp_q + AW'(pop);
            occ_q     <= occ_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // trace storage; stamp is the cycle count before this cycle's increment
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wp_q]   <= wb_rd_i;
            mem_data[wp_q] <= wb_data_i;
            mem_cyc[wp_q]  <= cnt_q[0];
        end
    end

    assign rd_data_o   = rd_data_q;
    assign sat_o       = sat_q;
    assign trc_valid_o = occ_q != '0;
    assign trc_rd_o    = trc_valid_o ? mem_rd[rp_q] : '0;
    assign trc_data_o  = trc_valid_o ? mem_data[rp_q] : '0;
    assign trc_cycle_o = trc_valid_o ? mem_cyc[rp_q] : '0;
endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb_pipe_perf_monitor: directed scoreboard bench for the perf counters and writeback trace FIFO
module tb_pipe_perf_monitor;
    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
        logic [31:0] cyc;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst, enable, clear, wb_reg_write, hazard_stall, filter_en, trc_ready;
    logic [4:0]  wb_rd, filter_rd;
    logic [63:0] wb_data;
    logic [3:0]  evt;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data, trc_cycle;
    logic        sat, trc_valid;
    logic [4:0]  trc_rd;
    logic [63:0] trc_data;
    logic [3:0]  s_rd_data, s_trc_cycle;
    logic        s_sat, s_trc_valid;
    logic [4:0]  s_trc_rd;
    logic [63:0] s_trc_data;

    int          n_assert = 0;
    int          n_fail = 0;
    rec_t        q[$];
    int unsigned m_cyc = 0;
    int          n;

    always #5 clk = ~clk;

    pipe_perf_monitor #(.XLEN(64), .CNT_W(32), .N_EVT(4), .TRACE_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .enable_i(enable), .clear_i(clear), .wb_reg_write_i(wb_reg_write),
        .wb_rd_i(wb_rd), .wb_data_i(wb_data), .hazard_stall_i(hazard_stall), .evt_i(evt),
        .filter_en_i(filter_en), .filter_rd_i(filter_rd), .rd_sel_i(rd_sel), .rd_data_o(rd_data),
        .sat_o(sat), .trc_valid_o(trc_valid), .trc_ready_i(trc_ready), .trc_rd_o(trc_rd),
        .trc_data_o(trc_data), .trc_cycle_o(trc_cycle)
    );

    pipe_perf_monitor #(.XLEN(64), .CNT_W(4), .N_EVT(4), .TRACE_DEPTH(8)) sdut (
        .clk(clk), .rst(rst), .enable_i(enable), .clear_i(clear), .wb_reg_write_i(wb_reg_write),
        .wb_rd_i(wb_rd), .wb_data_i(wb_data), .hazard_stall_i(hazard_stall), .evt_i(evt),
        .filter_en_i(filter_en), .filter_rd_i(filter_rd), .rd_sel_i(rd_sel), .rd_data_o(s_rd_data),
        .sat_o(s_sat), .trc_valid_o(s_trc_valid), .trc_ready_i(trc_ready), .trc_rd_o(s_trc_rd),
        .trc_data_o(s_trc_data), .trc_cycle_o(s_trc_cycle)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        bit   pop_m, cap_m;
        rec_t r;
        chk("trc_valid", trc_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("trc_rd", trc_rd, q[0].rd);
            chk("trc_data", trc_data, q[0].data);
            chk("trc_cycle", trc_cycle, q[0].cyc);
        end
        pop_m = (q.size() != 0) && trc_ready;
        cap_m = enable && wb_reg_write && (wb_rd != 0) && (!filter_en || wb_rd == filter_rd);
        r = '{wb_rd, wb_data, m_cyc};
        @(posedge clk);
        if (rst || clear) begin
            q.delete();
            m_cyc = 0;
        end else begin
            if (pop_m) void'(q.pop_front());
            if (cap_m && q.size() < 8) q.push_back(r);
            if (enable) m_cyc++;
        end
        @(negedge clk);
    endtask

    task automatic rd(input int sel, input logic [63:0] exp, input string tag);
        rd_sel = 3'(sel);
        cyc();
        chk(tag, rd_data, exp);
    endtask

    task automatic wr(input int r, input int d);
        wb_reg_write = 1'b1;
        wb_rd = 5'(r);
        wb_data = 64'(d);
        cyc();
        wb_reg_write = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        repeat (3) begin
            enable = 1'($urandom); clear = 1'($urandom); wb_reg_write = 1'($urandom);
            wb_rd = 5'($urandom); wb_data = {$urandom, $urandom}; hazard_stall = 1'($urandom);
            evt = 4'($urandom); filter_en = 1'($urandom); filter_rd = 5'($urandom);
            rd_sel = 3'($urandom); trc_ready = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0; enable = 0; clear = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
        hazard_stall = 0; evt = 0; filter_en = 0; filter_rd = 0; rd_sel = 0; trc_ready = 0;
        chk("rst_rd_data", rd_data, 0);
        chk("rst_sat", sat, 0);
        chk("rst_trc_valid", trc_valid, 0);
        chk("rst_trc_rd", trc_rd, 0);
        chk("rst_trc_data", trc_data, 0);
        chk("rst_trc_cycle", trc_cycle, 0);
        for (int s = 0; s < 8; s++) rd(s, 0, "rst_sel");

        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            hazard_stall = i < 3;
            evt = (i >= 8) ? 4'b0101 : 4'b0000;
            wb_reg_write = i < 5;
            wb_rd = (i < 4) ? 5'(i + 1) : 5'd0;
            wb_data = 64'(50 + i);
            cyc();
        end
        enable = 0; hazard_stall = 0; evt = 0; wb_reg_write = 0;
        rd(0, 10, "cnt_cycle");
        rd(1, 4, "cnt_retire");
        rd(2, 3, "cnt_stall");
        rd(3, 0, "cnt_drop");
        rd(4, 2, "cnt_evt0");
        rd(5, 0, "cnt_evt1");
        rd(6, 2, "cnt_evt2");
        rd(7, 0, "cnt_evt3");
        trc_ready = 1'b1;
        repeat (5) cyc();
        chk("cnt_drained", trc_valid, 0);
        trc_ready = 1'b0;

        pulse_clear();
        enable = 1'b1;
        for (int i = 0; i < 10; i++) wr(i + 1, 100 + i);
        enable = 1'b0;
        rd(3, 2, "ovf_drop");
        trc_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_rd", trc_rd, i + 1);
            chk("ovf_data", trc_data, 100 + i);
            cyc();
        end
        chk("ovf_empty", trc_valid, 0);
        trc_ready = 1'b0;

        pulse_clear();
        enable = 1'b1; filter_en = 1'b1; filter_rd = 5'd3;
        wr(2, 200); wr(3, 201); wr(5, 202); wr(3, 203);
        enable = 1'b0; filter_en = 1'b0;
        chk("flt_head_rd", trc_rd, 3);
        chk("flt_head_data", trc_data, 201);
        trc_ready = 1'b1;
        cyc();
        chk("flt_second", trc_data, 203);
        cyc();
        chk("flt_empty", trc_valid, 0);
        trc_ready = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) wr(10 + i, 300 + i);
        trc_ready = 1'b1;
        wr(20, 400);
        trc_ready = 1'b0; enable = 1'b0;
        rd(3, 0, "fullpop_drop");
        trc_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 12 && trc_valid; i++) begin
            n++;
            cyc();
        end
        chk("fullpop_occupancy", n, 8);
        trc_ready = 1'b0;

        pulse_clear();
        chk("sat_pre", s_sat, 0);
        enable = 1'b1;
        repeat (20) cyc();
        enable = 1'b0;
        cyc();
        chk("sat_set", s_sat, 1);
        rd_sel = 0;
        cyc();
        chk("sat_cycle", s_rd_data, 15);
        chk("sat_wide_cycle", rd_data, 20);
        repeat (3) cyc();
        chk("sat_sticky", s_sat, 1);
        chk("sat_wide", sat, 0);

        enable = 1'b1;
        for (int i = 0; i < 5; i++) wr(i + 1, 500 + i);
        enable = 1'b0;
        rd(1, 5, "clr_pre_retire");
        enable = 1'b1; clear = 1'b1;
        wb_reg_write = 1'b1; wb_rd = 5'd6; wb_data = 64'd600;
        cyc();
        enable = 1'b0; clear = 1'b0; wb_reg_write = 1'b0;
        chk("clr_valid", trc_valid, 0);
        chk("clr_rd_data", rd_data, 0);
        chk("clr_sat", s_sat, 0);
        rd(0, 0, "clr_cycle");
        rd(1, 0, "clr_retire");
        rd(3, 0, "clr_drop");
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
